// File: rtl/packet_arbiter_dual.sv
// packet_arbiter_dual: packet-granular round-robin merge of CHANNEL_NUMBER AXI-Stream inputs
// onto one registered output stage; the grant is taken on a routing header and held until TLAST.
module packet_arbiter_dual #(
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH = 4,
  parameter int DEST_WIDTH = 4,
  parameter int USER_WIDTH = 4,
  parameter int CHANNEL_NUMBER = 10,
  parameter int CHANNEL_NUMBER_WIDTH = $clog2(CHANNEL_NUMBER),
  parameter logic [ID_WIDTH-1:0] ROUTING_HEADER = '1
) (
  input  logic clk,
  input  logic rst,
  input  logic [CHANNEL_NUMBER-1:0] in_tvalid_i,
  output logic [CHANNEL_NUMBER-1:0] in_tready_o,
  input  logic [CHANNEL_NUMBER-1:0][DATA_WIDTH-1:0] in_tdata_i,
  input  logic [CHANNEL_NUMBER-1:0] in_tlast_i,
  input  logic [CHANNEL_NUMBER-1:0][ID_WIDTH-1:0] in_tid_i,
  input  logic [CHANNEL_NUMBER-1:0][DEST_WIDTH-1:0] in_tdest_i,
  input  logic [CHANNEL_NUMBER-1:0][USER_WIDTH-1:0] in_tuser_i,
  output logic out_tvalid_o,
  input  logic out_tready_i,
  output logic [DATA_WIDTH-1:0] out_tdata_o,
  output logic out_tlast_o,
  output logic [ID_WIDTH-1:0] out_tid_o,
  output logic [DEST_WIDTH-1:0] out_tdest_o,
  output logic [USER_WIDTH-1:0] out_tuser_o,
  output logic [CHANNEL_NUMBER_WIDTH-1:0] current_grant_o,
  output logic grant_active_o
);
  localparam int CW = CHANNEL_NUMBER_WIDTH;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;
  logic [0:0] state_q, state_d;
  logic [CW-1:0] grant_q, grant_d;
  logic tvalid_q, tvalid_d, tlast_q, tlast_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic [ID_WIDTH-1:0] tid_q, tid_d;
  logic [DEST_WIDTH-1:0] tdest_q, tdest_d;
  logic [USER_WIDTH-1:0] tuser_q, tuser_d;
  logic stage_ready, load, hit, found_hi, found_lo;
  logic [CW-1:0] win_hi, win_lo;
  assign stage_ready = !tvalid_q || out_tready_i;
  assign load = state_q == LOCKED && in_tvalid_i[grant_q] && stage_ready;
  // Descending scan leaves the lowest header index above the grant in win_hi, lowest at/below in win_lo
  always_comb begin
    hit = 1'b0;
    found_hi = 1'b0;
    found_lo = 1'b0;
    win_hi = '0;
    win_lo = '0;
    in_tready_o = '0;
    for (int i = CHANNEL_NUMBER - 1; i >= 0; i--) begin
      hit = in_tvalid_i[i] && in_tid_i[i] == ROUTING_HEADER;
      in_tready_o[i] = state_q == LOCKED && grant_q == CW'(i) && stage_ready;
      if (hit && CW'(i) > grant_q) begin
        found_hi = 1'b1;
        win_hi = CW'(i);
      end
      if (hit && CW'(i) <= grant_q) begin
        found_lo = 1'b1;
        win_lo = CW'(i);
      end
    end
  end
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    tvalid_d = load ? 1'b1 : (out_tready_i ? 1'b0 : tvalid_q);
    tdata_d = load ? in_tdata_i[grant_q] : tdata_q;
    tlast_d = load ? in_tlast_i[grant_q] : tlast_q;
    tid_d = load ? in_tid_i[grant_q] : tid_q;
    tdest_d = load ? in_tdest_i[grant_q] : tdest_q;
    tuser_d = load ? in_tuser_i[grant_q] : tuser_q;
    if (state_q == IDLE && (found_hi || found_lo)) begin
      state_d = LOCKED;
      grant_d = found_hi ? win_hi : win_lo;
    end
    if (load && in_tlast_i[grant_q]) state_d = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= CW'(CHANNEL_NUMBER - 1);
      tvalid_q <= 1'b0;
      tdata_q <= '0;
      tlast_q <= 1'b0;
      tid_q <= '0;
      tdest_q <= '0;
      tuser_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      tvalid_q <= tvalid_d;
      tdata_q <= tdata_d;
      tlast_q <= tlast_d;
      tid_q <= tid_d;
      tdest_q <= tdest_d;
      tuser_q <= tuser_d;
    end
  end
  assign out_tvalid_o = tvalid_q;
  assign out_tdata_o = tdata_q;
  assign out_tlast_o = tlast_q;
  assign out_tid_o = tid_q;
  assign out_tdest_o = tdest_q;
  assign out_tuser_o = tuser_q;
  assign current_grant_o = grant_q;
  assign grant_active_o = state_q == LOCKED;
endmodule
